// File: rtl/neuron_backprop_4in.sv
// Backward pass of the 4-input fixed-weight ReLU neuron: from the captured forward-pass
// sample and incoming error it produces dX = sat(floor(D*W)), G = sat(floor(D*X)) and GB = D.
module neuron_backprop_4in #(
  parameter int unsigned                  DATA_WIDTH = 8,
  parameter int unsigned                  FRAC_BITS  = 4,
  parameter logic signed [DATA_WIDTH-1:0] W1         = DATA_WIDTH'(8),
  parameter logic signed [DATA_WIDTH-1:0] W2         = DATA_WIDTH'(5),
  parameter logic signed [DATA_WIDTH-1:0] W3         = DATA_WIDTH'(-17),
  parameter logic signed [DATA_WIDTH-1:0] W4         = DATA_WIDTH'(-5)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         En,
  input  logic                         Run,
  input  logic signed [DATA_WIDTH-1:0] X1,
  input  logic signed [DATA_WIDTH-1:0] X2,
  input  logic signed [DATA_WIDTH-1:0] X3,
  input  logic signed [DATA_WIDTH-1:0] X4,
  input  logic signed [DATA_WIDTH-1:0] Y,
  input  logic signed [DATA_WIDTH-1:0] dY,
  output logic signed [DATA_WIDTH-1:0] dX1,
  output logic signed [DATA_WIDTH-1:0] dX2,
  output logic signed [DATA_WIDTH-1:0] dX3,
  output logic signed [DATA_WIDTH-1:0] dX4,
  output logic signed [DATA_WIDTH-1:0] G1,
  output logic signed [DATA_WIDTH-1:0] G2,
  output logic signed [DATA_WIDTH-1:0] G3,
  output logic signed [DATA_WIDTH-1:0] G4,
  output logic signed [DATA_WIDTH-1:0] GB,
  output logic                         Done
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StLoad, StGate, StMultiply, StShifting, StSaturate, StResult
  } state_e;

  state_e                state_q, state_d;
  logic signed [DW-1:0]  x_q [4];
  logic signed [DW-1:0]  x_d [4];
  logic signed [DW-1:0]  y_q, y_d, dy_q, dy_d, d_q, d_d;
  // Entries 0..3 hold D*Wi, entries 4..7 hold D*Xi.
  logic signed [PW-1:0]  prod_q [8];
  logic signed [PW-1:0]  prod_d [8];
  logic signed [DW-1:0]  sat_q [8];
  logic signed [DW-1:0]  sat_d [8];
  logic signed [DW-1:0]  dx_q [4];
  logic signed [DW-1:0]  dx_d [4];
  logic signed [DW-1:0]  g_q [4];
  logic signed [DW-1:0]  g_d [4];
  logic signed [DW-1:0]  gb_q, gb_d;
  logic                  done_q, done_d;

  logic signed [DW-1:0]  x_in [4];
  logic signed [DW-1:0]  w_arr [4];

  assign x_in  = '{X1, X2, X3, X4};
  assign w_arr = '{W1, W2, W3, W4};

  function automatic logic signed [PW-1:0] sext(input logic signed [DW-1:0] a);
    return {{DW{a[DW-1]}}, a};
  endfunction

  // In range when every bit from the sign bit down to bit DW-1 agrees.
  function automatic logic signed [DW-1:0] sat(input logic signed [PW-1:0] v);
    if (v[PW-1:DW-1] == {(DW + 1){v[PW-1]}}) begin
      return v[DW-1:0];
    end else if (v[PW-1]) begin
      return {1'b1, {(DW - 1){1'b0}}};
    end else begin
      return {1'b0, {(DW - 1){1'b1}}};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dy_d    = dy_q;
    d_d     = d_q;
    prod_d  = prod_q;
    sat_d   = sat_q;
    dx_d    = dx_q;
    g_d     = g_q;
    gb_d    = gb_q;
    done_d  = 1'b0;
    if (En) begin
      case (state_q)
        StIdle: begin
          if (Run) state_d = StLoad;
        end
        StLoad: begin
          state_d = StGate;
          x_d     = x_in;
          y_d     = Y;
          dy_d    = dY;
        end
        StGate: begin
          state_d = StMultiply;
          d_d     = (!y_q[DW-1] && (y_q != '0)) ? dy_q : '0;
        end
        StMultiply: begin
          state_d = StShifting;
          for (int i = 0; i < 4; i++) begin
            prod_d[i]     = sext(d_q) * sext(w_arr[i]);
            prod_d[i + 4] = sext(d_q) * sext(x_q[i]);
          end
        end
        StShifting: begin
          state_d = StSaturate;
          for (int i = 0; i < 8; i++) prod_d[i] = prod_q[i] >>> FRAC_BITS;
        end
        StSaturate: begin
          state_d = StResult;
          for (int i = 0; i < 8; i++) sat_d[i] = sat(prod_q[i]);
        end
        StResult: begin
          state_d = StIdle;
          for (int i = 0; i < 4; i++) begin
            dx_d[i] = sat_q[i];
            g_d[i]  = sat_q[i + 4];
          end
          gb_d   = d_q;
          done_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      y_q     <= '0;
      dy_q    <= '0;
      d_q     <= '0;
      gb_q    <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i]  <= '0;
        dx_q[i] <= '0;
        g_q[i]  <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        prod_q[i] <= '0;
        sat_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dy_q    <= dy_d;
      d_q     <= d_d;
      prod_q  <= prod_d;
      sat_q   <= sat_d;
      dx_q    <= dx_d;
      g_q     <= g_d;
      gb_q    <= gb_d;
      done_q  <= done_d;
    end
  end

  assign dX1  = dx_q[0];
  assign dX2  = dx_q[1];
  assign dX3  = dx_q[2];
  assign dX4  = dx_q[3];
  assign G1   = g_q[0];
  assign G2   = g_q[1];
  assign G3   = g_q[2];
  assign G4   = g_q[3];
  assign GB   = gb_q;
  assign Done = done_q;

endmodule

// File: tb/tb_neuron_backprop_4in.sv
// Self-checking bench for neuron_backprop_4in: table-driven vectors with a scoreboard queue,
// plus stall, abort and back-to-back sequences.
module tb_neuron_backprop_4in;

  typedef struct {
    int x1, x2, x3, x4, y, dy;
    int dx1, dx2, dx3, dx4, g1, g2, g3, g4, gb;
  } vec_t;

  logic              clk, rst, En, Run;
  logic signed [7:0] X1, X2, X3, X4, Y, dY;
  logic signed [7:0] dX1, dX2, dX3, dX4, G1, G2, G3, G4, GB;
  logic              Done;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [6];
  vec_t sb [$];

  neuron_backprop_4in dut (
    .clk (clk), .rst (rst), .En (En), .Run (Run),
    .X1 (X1), .X2 (X2), .X3 (X3), .X4 (X4), .Y (Y), .dY (dY),
    .dX1 (dX1), .dX2 (dX2), .dX3 (dX3), .dX4 (dX4),
    .G1 (G1), .G2 (G2), .G3 (G3), .G4 (G4), .GB (GB), .Done (Done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    X1 = 8'(v.x1); X2 = 8'(v.x2); X3 = 8'(v.x3); X4 = 8'(v.x4);
    Y  = 8'(v.y);  dY = 8'(v.dy);
  endtask

  task automatic scramble();
    X1 = 8'($urandom); X2 = 8'($urandom); X3 = 8'($urandom); X4 = 8'($urandom);
    Y  = 8'($urandom); dY = 8'($urandom);
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, ".dX1"}, dX1, e.dx1);
    check({tag, ".dX2"}, dX2, e.dx2);
    check({tag, ".dX3"}, dX3, e.dx3);
    check({tag, ".dX4"}, dX4, e.dx4);
    check({tag, ".G1"}, G1, e.g1);
    check({tag, ".G2"}, G2, e.g2);
    check({tag, ".G3"}, G3, e.g3);
    check({tag, ".G4"}, G4, e.g4);
    check({tag, ".GB"}, GB, e.gb);
  endtask

  // Scoreboard: every Done pops the oldest expected record.
  always @(posedge clk) begin
    #1;
    if (Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check_outputs("sb", sb.pop_front());
      end
    end
  end

  // One operation; En is low on edges ss..ss+sl-1 after the Run edge; optional Run toggling.
  task automatic do_op(input vec_t v, input int exp_lat, input int ss, input int sl,
                       input bit toggle);
    int lat;
    lat = 0;
    @(negedge clk);
    apply(v);
    Run = 1'b1;
    En  = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      En  = (n >= ss && n < ss + sl) ? 1'b0 : 1'b1;
      Run = toggle & n[0];
      if (n == 2) scramble();
      @(posedge clk);
      #1;
      if (Done) begin
        lat = n;
        break;
      end
    end
    check("latency", lat, exp_lat);
    @(negedge clk);
    Run = 1'b0;
    En  = 1'b1;
    @(posedge clk);
    #1;
    check("done_width", Done, 0);
  endtask

  initial begin
    vec_t zero_v;
    int   seen;
    vecs[0] = '{32, -16, 0, 127, 20, 16,     8, 5, -17, -5,       32, -16, 0, 127, 16};
    vecs[1] = '{32, -16, 0, 127, 0, 16,      0, 0, 0, 0,          0, 0, 0, 0, 0};
    vecs[2] = '{32, -16, 0, 127, -3, 16,     0, 0, 0, 0,          0, 0, 0, 0, 0};
    vecs[3] = '{127, -128, 1, -1, 1, 127,    63, 39, -128, -40,   127, -128, 7, -8, 127};
    vecs[4] = '{16, 0, 0, 0, 5, -1,          -1, -1, 1, 0,        -1, 0, 0, 0, -1};
    vecs[5] = '{-128, 100, -50, 7, 127, -128, -64, -40, 127, 40,  127, -128, 127, -56, -128};
    zero_v  = '{0, 0, 0, 0, 0, 0,            0, 0, 0, 0,          0, 0, 0, 0, 0};

    rst = 1'b1; En = 1'b1; Run = 1'b0;
    apply(zero_v);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", zero_v);
    check("reset.Done", Done, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_op(vecs[i], 6, 0, 0, 1'b0);

    // Stall three edges while in MULTIPLY, and toggle Run while busy.
    do_op(vecs[0], 9, 3, 3, 1'b1);
    repeat (10) @(posedge clk);

    // Abort: reset on edge k+3 of an operation.
    @(negedge clk);
    apply(vecs[5]);
    Run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    scramble();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("abort", zero_v);
    check("abort.Done", Done, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (Done) seen++;
    end
    check("abort_no_done", seen, 0);

    // Back-to-back with Run held high: Done at edges k+6, k+13, k+20.
    @(negedge clk);
    apply(vecs[3]);
    Run = 1'b1;
    sb.push_back(vecs[3]);
    @(posedge clk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 8) begin
        apply(vecs[4]);
        sb.push_back(vecs[4]);
      end else if (c == 15) begin
        apply(vecs[5]);
        sb.push_back(vecs[5]);
      end else if (c == 21) begin
        Run = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("b2b_done_c%0d", c), Done, (c == 6 || c == 13 || c == 20) ? 1 : 0);
    end

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
